// File: rtl/hvtx_timing_if.sv
// rtl/hvtx_timing_if.sv - video timing output bundle from hvtx_timing to the channel mux/encoder
interface hvtx_timing_if #(
  parameter int WID      = 12,
  parameter int FCNT_WID = 8
);
  logic [WID-1:0]      o_x;
  logic [WID-1:0]      o_y;
  logic                o_hs;
  logic                o_vs;
  logic                o_de;
  logic                o_preamble;
  logic                o_guard;
  logic                o_line_start;
  logic                o_frame_start;
  logic [FCNT_WID-1:0] o_frame_cnt;

  modport master (
    output o_x, o_y, o_hs, o_vs, o_de, o_preamble, o_guard,
           o_line_start, o_frame_start, o_frame_cnt
  );

  modport slave (
    input  o_x, o_y, o_hs, o_vs, o_de, o_preamble, o_guard,
           o_line_start, o_frame_start, o_frame_cnt
  );
endinterface

// File: rtl/hvtx_timing.sv
// rtl/hvtx_timing.sv - parametrised HDMI video timing generator (cursor -> decode flops -> output flops)
// Optional frame counter enabled by defining HVTX_TIMING_FRAME_CNT_EN.
module hvtx_timing #(
  parameter int WID      = 12,
  parameter int H_ACTIVE = 1280,
  parameter int H_FRONT  = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BACK   = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FRONT  = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 20,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int FCNT_WID = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_run,
  hvtx_timing_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int HSS     = H_ACTIVE + H_FRONT;
  localparam int HSE     = HSS + H_SYNC;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int VSS     = V_ACTIVE + V_FRONT;
  localparam int VSE     = VSS + V_SYNC;

  typedef logic [WID-1:0] pos_t;

  localparam pos_t H_LAST  = pos_t'(H_TOTAL - 1);
  localparam pos_t V_LAST  = pos_t'(V_TOTAL - 1);
  localparam pos_t H_ACT_P = pos_t'(H_ACTIVE);
  localparam pos_t V_ACT_P = pos_t'(V_ACTIVE);
  localparam pos_t V_PRE_P = pos_t'(V_ACTIVE - 1);
  localparam pos_t HSS_P   = pos_t'(HSS);
  localparam pos_t HSE_P   = pos_t'(HSE);
  localparam pos_t VSS_P   = pos_t'(VSS);
  localparam pos_t VSE_P   = pos_t'(VSE);
  localparam pos_t PRE_S   = pos_t'(H_TOTAL - 10);
  localparam pos_t GRD_S   = pos_t'(H_TOTAL - 2);
  localparam logic HS_ON   = (HS_POL != 0);
  localparam logic VS_ON   = (VS_POL != 0);

  if (H_BACK < 10) begin : g_bad_hback
    $fatal(1, "hvtx_timing: H_BACK must be at least 10");
  end
  if ((H_TOTAL >= 2**WID) || (V_TOTAL >= 2**WID)) begin : g_bad_total
    $fatal(1, "hvtx_timing: H_TOTAL/V_TOTAL do not fit in WID bits");
  end

  typedef struct packed {
    pos_t x;
    pos_t y;
    logic hs;
    logic vs;
    logic de;
    logic pre;
    logic grd;
    logic ls;
    logic fs;
  } stage_t;

  localparam stage_t STAGE_RST = '{x: H_LAST, y: V_LAST, hs: ~HS_ON, vs: ~VS_ON,
                                   de: 1'b0, pre: 1'b0, grd: 1'b0, ls: 1'b0, fs: 1'b0};

  pos_t   cur_x_q, cur_x_d;
  pos_t   cur_y_q, cur_y_d;
  logic   live_q, live_d;
  stage_t s1_q, s1_d;
  stage_t s2_q, s2_d;

  // live_q marks a position reached by advancing; the parked corner would
  // otherwise decode as a guard-band cycle.
  always_comb begin
    cur_x_d = H_LAST;
    cur_y_d = V_LAST;
    live_d  = 1'b0;
    if (i_run) begin
      live_d = 1'b1;
      if (cur_x_q == H_LAST) begin
        cur_x_d = '0;
        cur_y_d = (cur_y_q == V_LAST) ? '0 : cur_y_q + pos_t'(1);
      end else begin
        cur_x_d = cur_x_q + pos_t'(1);
        cur_y_d = cur_y_q;
      end
    end
  end

  logic hs_act;
  logic vs_act;
  logic pre_line;

  always_comb begin
    hs_act   = (cur_x_q >= HSS_P) && (cur_x_q < HSE_P);
    // vsync edges line up with the hsync leading edge of the first/last sync line
    vs_act   = ((cur_y_q == VSS_P) && (cur_x_q >= HSS_P)) ||
               ((cur_y_q >  VSS_P) && (cur_y_q <  VSE_P)) ||
               ((cur_y_q == VSE_P) && (cur_x_q <  HSS_P));
    pre_line = (cur_y_q == V_LAST) || (cur_y_q < V_PRE_P);

    s1_d     = STAGE_RST;
    s1_d.x   = cur_x_q;
    s1_d.y   = cur_y_q;
    s1_d.hs  = hs_act ? HS_ON : ~HS_ON;
    s1_d.vs  = vs_act ? VS_ON : ~VS_ON;
    s1_d.de  = (cur_x_q < H_ACT_P) && (cur_y_q < V_ACT_P);
    s1_d.pre = live_q && pre_line && (cur_x_q >= PRE_S) && (cur_x_q < GRD_S);
    s1_d.grd = live_q && pre_line && (cur_x_q >= GRD_S);
    s1_d.ls  = (cur_x_q == '0);
    s1_d.fs  = (cur_x_q == '0) && (cur_y_q == '0);

    s2_d     = s1_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cur_x_q <= H_LAST;
      cur_y_q <= V_LAST;
      live_q  <= 1'b0;
      s1_q    <= STAGE_RST;
      s2_q    <= STAGE_RST;
    end else begin
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      live_q  <= live_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

`ifdef HVTX_TIMING_FRAME_CNT_EN
  logic [FCNT_WID-1:0] cnt_q, cnt_d;

  // origin is only reachable by advancing, so a staged frame_start is a counted entry
  always_comb begin
    cnt_d = cnt_q;
    if (s1_q.fs) begin
      cnt_d = cnt_q + {{(FCNT_WID-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign vid.o_frame_cnt = cnt_q;
`else
  assign vid.o_frame_cnt = {FCNT_WID{1'b0}};
`endif

  assign vid.o_x           = s2_q.x;
  assign vid.o_y           = s2_q.y;
  assign vid.o_hs          = s2_q.hs;
  assign vid.o_vs          = s2_q.vs;
  assign vid.o_de          = s2_q.de;
  assign vid.o_preamble    = s2_q.pre;
  assign vid.o_guard       = s2_q.grd;
  assign vid.o_line_start  = s2_q.ls;
  assign vid.o_frame_start = s2_q.fs;
endmodule
